// File: rtl/game_state_ctrl.sv
// game_state_ctrl: synchronises active-low start/dead and runs the TITLE/PLAY/RESPAWN/OVER game FSM.
// Optional pause is enabled with `define GAME_PAUSE_EN. State and outputs update 2 edges after an input edge is sampled.
// No backpressure: events are edge-triggered, and a fall that arrives while it is ignored is dropped.
module game_state_ctrl #(
    parameter int LIVES          = 3,
    parameter int LIVES_W        = 2,
    parameter int RESPAWN_FRAMES = 60,
    parameter int OVER_FRAMES    = 180,
    parameter int TIMER_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dead,
    input  logic               frame_tick,
    output logic               status,
    output logic [2:0]         state,
    output logic [LIVES_W-1:0] lives,
    output logic               run_en,
    output logic               game_over
);

    localparam logic [2:0] S_TITLE   = 3'd0;
    localparam logic [2:0] S_PLAY    = 3'd1;
    localparam logic [2:0] S_RESPAWN = 3'd2;
    localparam logic [2:0] S_OVER    = 3'd3;
    localparam logic [2:0] S_PAUSE   = 3'd4;

    localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE    = LIVES_W'(1);
    localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_FRAMES);
    localparam logic [TIMER_W-1:0] OVER_LOAD    = TIMER_W'(OVER_FRAMES);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

    logic start_s1_q, start_s2_q, start_dly_q;
    logic dead_s1_q,  dead_s2_q,  dead_dly_q;
    logic start_fall, dead_fall;

    logic [2:0]         state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               status_q, status_d;
    logic               run_en_q, run_en_d;
    logic               game_over_q, game_over_d;

    // Synchronisers preset high (inactive) so reset release never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_s1_q  <= 1'b1;
            start_s2_q  <= 1'b1;
            start_dly_q <= 1'b1;
            dead_s1_q   <= 1'b1;
            dead_s2_q   <= 1'b1;
            dead_dly_q  <= 1'b1;
        end else begin
            start_s1_q  <= start;
            start_s2_q  <= start_s1_q;
            start_dly_q <= start_s2_q;
            dead_s1_q   <= dead;
            dead_s2_q   <= dead_s1_q;
            dead_dly_q  <= dead_s2_q;
        end
    end

    assign start_fall = start_dly_q & ~start_s2_q;
    assign dead_fall  = dead_dly_q  & ~dead_s2_q;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        timer_d = timer_q;
        case (state_q)
            S_TITLE: begin
                if (start_fall) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_INIT;
                end
            end
            S_PLAY: begin
                // Death outranks a simultaneous start press.
                if (dead_fall) begin
                    if (lives_q > LIVES_ONE) begin
                        state_d = S_RESPAWN;
                        lives_d = lives_q - LIVES_ONE;
                        timer_d = RESPAWN_LOAD;
                    end else begin
                        state_d = S_OVER;
                        lives_d = '0;
                        timer_d = OVER_LOAD;
                    end
                end
`ifdef GAME_PAUSE_EN
                else if (start_fall) begin
                    state_d = S_PAUSE;
                end
`endif
            end
            S_RESPAWN: begin
                if (frame_tick) begin
                    if (timer_q <= TIMER_ONE) begin
                        state_d = S_PLAY;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
            end
            S_OVER: begin
                lives_d = '0;
                if (frame_tick) begin
                    if (timer_q <= TIMER_ONE) begin
                        state_d = S_TITLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (start_fall) begin
                    state_d = S_PLAY;
                end
            end
`endif
            default: begin
                state_d = S_TITLE;
                lives_d = '0;
                timer_d = '0;
            end
        endcase
    end

    // Flag outputs are derived from the next state so they change on the same edge as state.
    always_comb begin
        status_d    = (state_d == S_TITLE) || (state_d == S_PLAY) || (state_d == S_PAUSE);
        run_en_d    = (state_d == S_PLAY);
        game_over_d = (state_d == S_OVER) && (state_q != S_OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_TITLE;
            lives_q     <= '0;
            timer_q     <= '0;
            status_q    <= 1'b1;
            run_en_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            timer_q     <= timer_d;
            status_q    <= status_d;
            run_en_q    <= run_en_d;
            game_over_q <= game_over_d;
        end
    end

    assign state     = state_q;
    assign lives     = lives_q;
    assign status    = status_q;
    assign run_en    = run_en_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: stimulus queues expected output vectors, a negedge monitor
// pops one entry per observed output change and compares value and arrival cycle.
module tb_game_state_ctrl;
    localparam int LW = 2;
    localparam int RF = 60;
    localparam int OF = 180;
    localparam logic [2:0] TITLE = 3'd0, PLAY = 3'd1, RESPAWN = 3'd2, OVER = 3'd3, PAUSE = 3'd4;

    logic          clk = 1'b0;
    logic          reset, start, dead, frame_tick;
    logic          status, run_en, game_over;
    logic [2:0]    state;
    logic [LW-1:0] lives;

    game_state_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .dead(dead), .frame_tick(frame_tick),
        .status(status), .state(state), .lives(lives), .run_en(run_en), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        int         cyc;
        string      nm;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         last_c = 0;
    logic [7:0] prev = 8'hFF;
    exp_t       dummy;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of {state, lives, status, run_en, game_over} must match the next queued entry.
    always @(negedge clk) begin : mon
        logic [7:0] cur;
        exp_t       e;
        cur = {state, lives, status, run_en, game_over};
        if (cur !== prev) begin
            prev = cur;
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_event: got %h (state,lives,status,run,go) at cycle %0d, expected no change", cur, cyc);
            end else begin
                e = q.pop_front();
                if (cur === e.v) n_pass++;
                else $display("FAIL %s: got %h expected %h", e.nm, cur, e.v);
                if (e.cyc >= 0) begin
                    n_checks++;
                    if (cyc == e.cyc) n_pass++;
                    else $display("FAIL %s_cycle: got cycle %0d expected %0d", e.nm, cyc, e.cyc);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [2:0] st, input logic [LW-1:0] lv,
                                input logic stt, input logic run, input logic go, input string nm);
        exp_t e;
        e.v   = {st, lv, stt, run, go};
        e.cyc = -1;
        e.nm  = nm;
        return e;
    endfunction

    // Drive start and/or dead low for 'hold' cycles; the state change lands 3 edges after the drive point.
    task automatic press(input logic s, input logic d, input int hold, input logic do_exp, input exp_t e);
        @(negedge clk);
        if (do_exp) begin
            e.cyc  = cyc + 3;
            last_c = e.cyc;
            q.push_back(e);
        end
        if (s) start = 1'b0;
        if (d) dead = 1'b0;
        repeat (hold) @(negedge clk);
        start = 1'b1;
        dead  = 1'b1;
    endtask

    task automatic tick(input logic do_exp, input exp_t e);
        @(negedge clk);
        if (do_exp) begin
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(1'b0, dummy);
    endtask

    task automatic quiet(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) break;
        end
        n_checks++;
        if (q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s_timeout: %0d expected events outstanding, required 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        dummy      = mk(TITLE, 0, 1'b1, 1'b0, 1'b0, "none");
        reset      = 1'b0;
        start      = 1'b1;
        dead       = 1'b1;
        frame_tick = 1'b0;
        q.push_back(mk(TITLE, 0, 1'b1, 1'b0, 1'b0, "reset_state"));
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Idle after reset: no transition; tick and dead are ignored in TITLE.
        quiet(10);
        tick(1'b0, dummy);
        press(1'b0, 1'b1, 3, 1'b0, dummy);
        quiet(8);
        drain("t1_idle");

        press(1'b1, 1'b0, 1, 1'b1, mk(PLAY, 3, 1'b1, 1'b1, 1'b0, "t2_start"));
        drain("t2");

        // Held dead gives exactly one death; respawn lasts exactly RF ticks.
        press(1'b0, 1'b1, 10, 1'b1, mk(RESPAWN, 2, 1'b0, 1'b0, 1'b0, "t3_death"));
        drain("t3a");
        ticks(RF - 1);
        quiet(5);
        tick(1'b1, mk(PLAY, 2, 1'b1, 1'b1, 1'b0, "t3_respawn_done"));
        drain("t3b");

        // Second death; a dead fall coinciding with respawn expiry is dropped.
        press(1'b0, 1'b1, 1, 1'b1, mk(RESPAWN, 1, 1'b0, 1'b0, 1'b0, "t4_death2"));
        drain("t4a");
        ticks(RF - 1);
        @(negedge clk); dead = 1'b0;
        @(negedge clk); dead = 1'b1;
        tick(1'b1, mk(PLAY, 1, 1'b1, 1'b1, 1'b0, "t4_expiry_drops_dead"));
        quiet(8);
        drain("t4b");

        // Last life: OVER with one-cycle game_over pulse.
        press(1'b0, 1'b1, 1, 1'b1, mk(OVER, 0, 1'b0, 1'b0, 1'b1, "t4_over"));
        dummy     = mk(OVER, 0, 1'b0, 1'b0, 1'b0, "t4_go_clear");
        dummy.cyc = last_c + 1;
        q.push_back(dummy);
        dummy     = mk(TITLE, 0, 1'b1, 1'b0, 1'b0, "none");
        drain("t4c");
        press(1'b1, 1'b0, 2, 1'b0, dummy);
        press(1'b0, 1'b1, 2, 1'b0, dummy);
        ticks(OF - 1);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        tick(1'b1, mk(TITLE, 0, 1'b1, 1'b0, 1'b0, "t4_over_done"));
        quiet(8);
        drain("t4d");

        press(1'b1, 1'b0, 1, 1'b1, mk(PLAY, 3, 1'b1, 1'b1, 1'b0, "t5_start"));
        drain("t5a");
        press(1'b0, 1'b1, 1, 1'b1, mk(RESPAWN, 2, 1'b0, 1'b0, 1'b0, "t5_death"));
        drain("t5b");
        ticks(RF - 1);
        tick(1'b1, mk(PLAY, 2, 1'b1, 1'b1, 1'b0, "t5_respawn_done"));
        drain("t5c");
`ifndef GAME_PAUSE_EN
        press(1'b1, 1'b0, 4, 1'b0, dummy);
        quiet(6);
        drain("t6_start_ignored");
`endif
        // Simultaneous start and dead: death taken, no pause.
        press(1'b1, 1'b1, 1, 1'b1, mk(RESPAWN, 1, 1'b0, 1'b0, 1'b0, "t5_simul"));
        drain("t5d");
        // Reset just after a rising edge must take effect before the next one.
        @(negedge clk);
        dummy     = mk(TITLE, 0, 1'b1, 1'b0, 1'b0, "t5_async_reset");
        dummy.cyc = cyc + 1;
        q.push_back(dummy);
        dummy     = mk(TITLE, 0, 1'b1, 1'b0, 1'b0, "none");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        quiet(5);
        drain("t5e");

`ifdef GAME_PAUSE_EN
        press(1'b1, 1'b0, 1, 1'b1, mk(PLAY, 3, 1'b1, 1'b1, 1'b0, "t6_start"));
        drain("t6a");
        press(1'b1, 1'b0, 1, 1'b1, mk(PAUSE, 3, 1'b1, 1'b0, 1'b0, "t6_pause"));
        drain("t6b");
        press(1'b0, 1'b1, 2, 1'b0, dummy);
        tick(1'b0, dummy);
        quiet(6);
        press(1'b1, 1'b0, 1, 1'b1, mk(PLAY, 3, 1'b1, 1'b1, 1'b0, "t6_resume"));
        drain("t6c");
`endif

        quiet(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
